wb_timer: RTL and testbench

Memory-mapped machine timer that is a Wishbone slave responder on the pipelined core bus. It holds a 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register, and raises a level timer interrupt to the core when `mtime >= mtimecmp`. Bus masters access it through the `wishbone.slave` modport, and the interconnect decodes its base address.

---
 rtl/types.sv | 7 +
 rtl/wb_timer_pkg.sv | 29 ++
 rtl/wishbone.sv | 17 +
 rtl/tick_gen.sv | 32 +++
 rtl/wb_timer.sv | 108 ++++++++++
 tb/tb_wb_timer.sv | 256 +++++++++++++++++++++++++
 6 files changed

// File: rtl/types.sv
// Shared bus types for the core interconnect.
//   word_t : 32-bit Wishbone data/address word
//   bsel_t : 4-bit byte-lane select
package types;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  bsel_t;
endpackage

// File: rtl/wb_timer_pkg.sv
// Constants and helpers for the memory-mapped machine timer.
//   reg_idx_e    : register index decoded from adr[4:2]
//   CTRL_EN_BIT  : position of the enable bit in ctrl
//   MTIMECMP_RST : reset value of mtimecmp (never fires after reset)
//   merge_bytes  : byte-lane write merge
package wb_timer_pkg;
  import types::word_t;
  import types::bsel_t;

  typedef enum logic [2:0] {
    REG_MTIME_LO    = 3'd0,
    REG_MTIME_HI    = 3'd1,
    REG_MTIMECMP_LO = 3'd2,
    REG_MTIMECMP_HI = 3'd3,
    REG_CTRL        = 3'd4
  } reg_idx_e;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam logic [63:0] MTIMECMP_RST = '1;

  function automatic word_t merge_bytes(word_t old_v, word_t new_v, bsel_t sel);
    word_t r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction
endpackage

// File: rtl/wishbone.sv
// Pipelined Wishbone bus bundle.
//   master : drives stb, adr, sel, we, dat_w; receives stall, ack, dat_r
//   slave  : mirror of master
interface wishbone;
  import types::*;
  logic  stb;
  logic  stall;
  logic  ack;
  word_t adr;
  bsel_t sel;
  logic  we;
  word_t dat_r;
  word_t dat_w;

  modport master (output stb, adr, sel, we, dat_w, input stall, ack, dat_r);
  modport slave  (input stb, adr, sel, we, dat_w, output stall, ack, dat_r);
endinterface

// File: rtl/tick_gen.sv
// Prescaler for the machine timer: emits one tick every PRESCALE enabled cycles.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   en    : count enable; pre holds while low
//   clr   : restart the prescale period (pre -> 0)
//   tick  : high in the cycle where pre == PRESCALE-1 and en is high
module tick_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0] pre_q, pre_d;

  assign tick = en && (pre_q == PRE_MAX);

  always_comb begin
    pre_d = pre_q;
    if (clr)      pre_d = '0;
    else if (en)  pre_d = tick ? '0 : pre_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end
endmodule

// File: rtl/wb_timer.sv
// Memory-mapped machine timer (Wishbone pipelined slave).
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : wishbone.slave; single-cycle ack, never stalls
//   irq   : registered level interrupt, mtime >= mtimecmp
// Map on adr[4:2]: 0/1 mtime lo/hi, 2/3 mtimecmp lo/hi, 4 ctrl (bit0 en),
// 5..7 read zero, writes ignored.
module wb_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  wishbone.slave bus,
  output logic   irq
);
  import types::*;
  import wb_timer_pkg::*;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic        ack_q;
  word_t       dat_r_q, dat_r_d;
  logic        irq_q;

  reg_idx_e    idx;
  logic        accept, wr, mtime_wr, tick;
  word_t       rdata;
  logic        unused_adr;

  assign unused_adr = ^{bus.adr[31:5], bus.adr[1:0]};

  assign accept   = bus.stb;
  assign idx      = reg_idx_e'(bus.adr[4:2]);
  assign wr       = accept && bus.we;
  assign mtime_wr = wr && ((idx == REG_MTIME_LO) || (idx == REG_MTIME_HI));

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en_q),
    .clr  (mtime_wr),
    .tick (tick)
  );

  always_comb begin
    rdata = '0;
    case (idx)
      REG_MTIME_LO:    rdata = mtime_q[31:0];
      REG_MTIME_HI:    rdata = mtime_q[63:32];
      REG_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
      REG_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
      REG_CTRL:        rdata[CTRL_EN_BIT] = en_q;
      default:         rdata = '0;
    endcase
  end

  // A write to either mtime half rebuilds mtime_d from the pre-increment value,
  // which drops the whole 64-bit increment (carry included) for that cycle.
  always_comb begin
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    if (wr) begin
      case (idx)
        REG_MTIME_LO:
          mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], bus.dat_w, bus.sel)};
        REG_MTIME_HI:
          mtime_d = {merge_bytes(mtime_q[63:32], bus.dat_w, bus.sel), mtime_q[31:0]};
        REG_MTIMECMP_LO:
          mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], bus.dat_w, bus.sel);
        REG_MTIMECMP_HI:
          mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], bus.dat_w, bus.sel);
        REG_CTRL:
          if (bus.sel[0]) en_d = bus.dat_w[CTRL_EN_BIT];
        default: ;
      endcase
    end
  end

  always_comb begin
    dat_r_d = '0;
    if (accept && !bus.we) dat_r_d = rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      en_q       <= 1'b0;
      ack_q      <= 1'b0;
      dat_r_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      ack_q      <= accept;
      dat_r_q    <= dat_r_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  assign bus.stall = 1'b0;
  assign bus.ack   = ack_q;
  assign bus.dat_r = dat_r_q;
  assign irq       = irq_q;
endmodule

// File: tb/tb_wb_timer.sv
module tb_wb_timer;
  import types::*;

  localparam int unsigned MP = 1;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  stb = 1'b0;
  logic  we = 1'b0;
  word_t adr = '0;
  bsel_t sel = '0;
  word_t dat_w = '0;
  logic  dut_sel = 1'b0;
  logic  irq1, irq4;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference state for the PRESCALE=1 instance
  logic [63:0] m_mtime, m_cmp;
  logic        m_en;
  int unsigned m_pre;

  always #5 clk = ~clk;

  wishbone bus1();
  wishbone bus4();

  assign bus1.stb   = stb & ~dut_sel;
  assign bus1.we    = we;
  assign bus1.adr   = adr;
  assign bus1.sel   = sel;
  assign bus1.dat_w = dat_w;
  assign bus4.stb   = stb & dut_sel;
  assign bus4.we    = we;
  assign bus4.adr   = adr;
  assign bus4.sel   = sel;
  assign bus4.dat_w = dat_w;

  wb_timer #(.PRESCALE(MP)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus1), .irq(irq1));
  wb_timer #(.PRESCALE(4))  u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4), .irq(irq4));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  function automatic logic [31:0] model_read(int unsigned i);
    case (i)
      0: return m_mtime[31:0];
      1: return m_mtime[63:32];
      2: return m_cmp[31:0];
      3: return m_cmp[63:32];
      4: return {31'd0, m_en};
      default: return 32'd0;
    endcase
  endfunction

  // One clock: derive expectations from the inputs presented now, step the edge,
  // compare, then commit the reference state.
  task automatic cycle();
    logic        s1, e_ack, e_irq, rs, tk;
    logic [31:0] e_dat;
    logic [63:0] n_mtime, n_cmp;
    logic        n_en;
    int unsigned n_pre, i;
    word_t       a;
    a  = adr;
    i  = int'(a[4:2]);
    s1 = stb && !dut_sel;
    rs = rst_n;
    if (!rs) begin
      e_ack = 0; e_dat = 0; e_irq = 0;
      n_mtime = 0; n_cmp = '1; n_en = 0; n_pre = 0;
    end else begin
      e_ack = s1;
      e_dat = (s1 && !we) ? model_read(i) : 32'd0;
      e_irq = (m_mtime >= m_cmp);
      tk = m_en && (m_pre == MP - 1);
      n_mtime = tk ? m_mtime + 64'd1 : m_mtime;
      n_pre   = m_en ? (tk ? 0 : m_pre + 1) : m_pre;
      n_cmp   = m_cmp;
      n_en    = m_en;
      if (s1 && we) begin
        case (i)
          0: begin n_mtime = {m_mtime[63:32], lane_merge(m_mtime[31:0], dat_w, sel)}; n_pre = 0; end
          1: begin n_mtime = {lane_merge(m_mtime[63:32], dat_w, sel), m_mtime[31:0]}; n_pre = 0; end
          2: n_cmp[31:0]  = lane_merge(m_cmp[31:0], dat_w, sel);
          3: n_cmp[63:32] = lane_merge(m_cmp[63:32], dat_w, sel);
          4: if (sel[0]) n_en = dat_w[0];
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    check("ack", 64'(bus1.ack), 64'(e_ack));
    check("irq", 64'(irq1), 64'(e_irq));
    if (e_ack || !rs) check("dat_r", 64'(bus1.dat_r), 64'(e_dat));
    m_mtime = n_mtime; m_cmp = n_cmp; m_en = n_en; m_pre = n_pre;
  endtask

  task automatic set_req(input logic which, input logic w, input int unsigned idx,
                         input word_t d, input bsel_t s);
    word_t a;
    a = $urandom;
    a[4:2] = idx[2:0];
    dut_sel = which; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
  endtask

  task automatic bus_write(input logic which, input int unsigned idx, input word_t d, input bsel_t s);
    set_req(which, 1'b1, idx, d, s);
    cycle();
    stb = 1'b0;
  endtask

  task automatic bus_read(input logic which, input int unsigned idx, output word_t d, output logic ack);
    set_req(which, 1'b0, idx, $urandom, 4'hF);
    cycle();
    d   = which ? bus4.dat_r : bus1.dat_r;
    ack = which ? bus4.ack : bus1.ack;
    stb = 1'b0;
  endtask

  task automatic idle();
    stb = 1'b0;
    cycle();
  endtask

  initial begin
    word_t d;
    logic  a;
    int    reach, rise;
    logic [31:0] rst_exp [5];
    rst_exp[0] = 32'h0; rst_exp[1] = 32'h0; rst_exp[2] = 32'hFFFF_FFFF;
    rst_exp[3] = 32'hFFFF_FFFF; rst_exp[4] = 32'h0;
    m_mtime = 0; m_cmp = '1; m_en = 0; m_pre = 0;

    // reset defaults
    rst_n = 1'b0;
    repeat (3) idle();
    rst_n = 1'b1;
    check("rst_stall", 64'(bus1.stall), 64'd0);
    for (int unsigned r = 0; r < 5; r++) begin
      bus_read(1'b0, r, d, a);
      check("rst_reg", 64'(d), 64'(rst_exp[r]));
      check("rst_ack", 64'(a), 64'd1);
    end
    idle();
    check("rst_irq", 64'(irq1), 64'd0);

    // byte lanes, back-to-back write then read
    bus_write(1'b0, 2, 32'hAABB_CCDD, 4'b0101);
    check("bl_wr_ack", 64'(bus1.ack), 64'd1);
    bus_read(1'b0, 2, d, a);
    check("bl_rd_ack", 64'(a), 64'd1);
    check("bl_data", 64'(d), 64'hFFBB_FFDD);
    bus_write(1'b0, 2, 32'hFFFF_FFFF, 4'hF);

    // counting on the PRESCALE=4 instance
    bus_write(1'b1, 4, 32'h1, 4'hF);
    check("cnt_wr_ack", 64'(bus4.ack), 64'd1);
    repeat (40) idle();
    bus_read(1'b1, 0, d, a);
    check("cnt_ack", 64'(a), 64'd1);
    check("cnt_val", (d >= 9 && d <= 11) ? 64'd10 : 64'(d), 64'd10);

    // interrupt
    bus_write(1'b0, 0, 32'h0, 4'hF);
    bus_write(1'b0, 1, 32'h0, 4'hF);
    bus_write(1'b0, 3, 32'h0, 4'hF);
    bus_write(1'b0, 2, 32'h5, 4'hF);
    bus_write(1'b0, 4, 32'h1, 4'hF);
    reach = -1; rise = -1;
    for (int n = 0; n < 20; n++) begin
      idle();
      if (m_mtime == 64'd5 && reach < 0) reach = n;
      if (irq1 && rise < 0) rise = n;
    end
    check("irq_rise_lag", 64'(rise - reach), 64'd1);
    bus_write(1'b0, 3, 32'h1, 4'hF);
    check("irq_hold", 64'(irq1), 64'd1);
    idle();
    check("irq_drop", 64'(irq1), 64'd0);

    // carry into the high half
    bus_write(1'b0, 0, 32'hFFFF_FFFF, 4'hF);
    bus_write(1'b0, 1, 32'h0, 4'hF);
    idle();
    bus_read(1'b0, 1, d, a);
    check("carry_hi", 64'(d), 64'd1);

    // low-half write on a carrying tick suppresses the carry
    bus_write(1'b0, 4, 32'h0, 4'hF);
    bus_write(1'b0, 1, 32'h7, 4'hF);
    bus_write(1'b0, 0, 32'hFFFF_FFFF, 4'hF);
    bus_write(1'b0, 4, 32'h1, 4'hF);
    bus_write(1'b0, 0, 32'h1234_5678, 4'hF);
    bus_read(1'b0, 0, d, a);
    check("coll_lo", 64'(d), 64'h1234_5678);
    bus_read(1'b0, 1, d, a);
    check("coll_hi", 64'(d), 64'd7);

    // wrap-around
    bus_write(1'b0, 4, 32'h0, 4'hF);
    bus_write(1'b0, 1, 32'hFFFF_FFFF, 4'hF);
    bus_write(1'b0, 0, 32'hFFFF_FFFF, 4'hF);
    bus_write(1'b0, 4, 32'h1, 4'hF);
    idle();
    check("wrap_irq_hi", 64'(irq1), 64'd1);
    idle();
    check("wrap_irq_lo", 64'(irq1), 64'd0);
    bus_read(1'b0, 1, d, a);
    check("wrap_hi", 64'(d), 64'd0);
    bus_write(1'b0, 4, 32'h0, 4'hF);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int unsigned ri;
      word_t rd;
      ri = $urandom_range(0, 7);
      rd = (ri == 1 || ri == 3) ? word_t'($urandom_range(0, 2)) : word_t'($urandom);
      if ($urandom_range(0, 9) < 7) begin
        set_req(1'b0, 1'($urandom_range(0, 1)), ri, rd, bsel_t'($urandom_range(0, 15)));
        cycle();
      end else begin
        idle();
      end
    end
    stb = 1'b0;

    // reset during an accepted read
    set_req(1'b0, 1'b0, 0, 32'h0, 4'hF);
    rst_n = 1'b0;
    cycle();
    check("rmid_ack", 64'(bus1.ack), 64'd0);
    stb = 1'b0;
    rst_n = 1'b1;
    bus_read(1'b0, 6, d, a);
    check("unmapped_data", 64'(d), 64'd0);
    check("unmapped_ack", 64'(a), 64'd1);
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
